uart_tx_buffered: RTL and testbench

//  Buffered UART transmitter: byte FIFO in front of a serial TX engine driving txd.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_fifo.sv | 80 ++++++++
 rtl/uart_tx_buffered.sv | 219 +++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, parity encodings, TX FSM states and
// a parity helper. Used by uart_tx_fifo and uart_tx_buffered.
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // True when the parity selection inserts a parity bit (11 behaves as none).
    function automatic logic parity_enabled(input logic [1:0] sel);
        return (sel == PAR_EVEN) || (sel == PAR_ODD);
    endfunction

    // Parity bit value for a byte: even -> ^data, odd -> ~^data.
    function automatic logic parity_value(input logic [1:0] sel, input logic [DATA_W-1:0] data);
        return (sel == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous DEPTH x DATA_W byte FIFO feeding the UART TX engine.
// Ports:
//   mclk, n_reset     clock, async active-low reset
//   push_i, wr_data_i push request and byte (accepted if not full, or if popping)
//   pop_i             pop head (ignored when empty)
//   head_data_c       combinational view of the head entry
//   full_o, empty_o   registered occupancy flags
//   level_o           registered occupancy 0..DEPTH
//   overflow_o        one-cycle pulse after a push was dropped
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              mclk,
    input  logic              n_reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_c,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o
);

    localparam int unsigned LVL_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full_q, empty_q, overflow_q;
    logic              push_ok, pop_ok;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_q || pop_i);
    assign pop_ok  = pop_i && !empty_q;

    // Occupancy next-state.
    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Pointers and flags; pointers wrap naturally because DEPTH is 2**ADDR_W.
    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            level_q    <= level_d;
            full_q     <= (level_d == LVL_W'(DEPTH));
            empty_q    <= (level_d == '0);
            overflow_q <= push_i && !push_ok;
        end
    end

    // Storage array; no reset needed, contents are qualified by the pointers.
    always_ff @(posedge mclk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign head_data_c = mem_q[rd_ptr_q];
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO in front of a serial TX engine.
// Frames are start + 8 data bits (LSB first) + optional parity + 1/2 stop bits;
// the engine drains the FIFO back-to-back with no idle gap between frames.
// Ports:
//   mclk, n_reset            clock, async active-low reset
//   baud_max_cnt             mclk cycles per bit (0 behaves as 1)
//   parity_sel, stop_sel     frame format, latched at the start of each frame
//   wr_data, wr_en           host byte push
//   cts_n                    clear-to-send, active-low (only with UART_TX_CTS_EN)
//   full, empty, level       FIFO status (registered)
//   overflow                 pulse: push dropped because FIFO was full
//   busy, done               frame in progress / pulse after last stop bit
//   txd                      serial output, idle high
// Build option: define UART_TX_CTS_EN to add cts_n flow control.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              mclk,
    input  logic              n_reset,
    input  logic [15:0]       baud_max_cnt,
    input  logic [1:0]        parity_sel,
    input  logic              stop_sel,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
`ifdef UART_TX_CTS_EN
    input  logic              cts_n,
`endif
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              busy,
    output logic              done,
    output logic              txd
);

    localparam int unsigned BAUD_W = 16;
    localparam int unsigned BIT_W  = 3;

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [BAUD_W-1:0] baud_max_q, baud_max_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              has_par_q, has_par_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pop_c, load_c, baud_tc_c, can_start_c;
    logic [DATA_W-1:0] head_c;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .mclk        (mclk),
        .n_reset     (n_reset),
        .push_i      (wr_en),
        .wr_data_i   (wr_data),
        .pop_i       (pop_c),
        .head_data_c (head_c),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level),
        .overflow_o  (overflow)
    );

`ifdef UART_TX_CTS_EN
    logic cts_meta_q, cts_sync_q;

    // Two-flop synchroniser; resets to "not clear" so nothing starts early.
    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    assign can_start_c = !cts_sync_q;
`else
    assign can_start_c = 1'b1;
`endif

    // baud_max_q holds the effective (non-zero) period of the current frame.
    assign baud_tc_c = (baud_cnt_q == (baud_max_q - BAUD_W'(1)));

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        baud_max_d = baud_max_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        has_par_d  = has_par_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        txd_d      = txd_q;
        done_d     = 1'b0;
        load_c     = 1'b0;
        pop_c      = 1'b0;

        if (state_q == ST_IDLE || baud_tc_c) baud_cnt_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (!empty && can_start_c) load_c = 1'b1;
            end
            ST_START: begin
                if (baud_tc_c) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_tc_c) begin
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        if (has_par_q) begin
                            state_d = ST_PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        // shift_q[0] is always the bit currently on the line.
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tc_c) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                    txd_d     = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_tc_c) begin
                    if (stop2_q && bit_cnt_q == '0) begin
                        bit_cnt_d = BIT_W'(1);
                    end else begin
                        done_d = 1'b1;
                        if (!empty && can_start_c) begin
                            load_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            txd_d   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Pop the head and latch the frame configuration for the next frame.
        if (load_c) begin
            pop_c      = 1'b1;
            state_d    = ST_START;
            txd_d      = 1'b0;
            baud_cnt_d = '0;
            shift_d    = head_c;
            has_par_d  = parity_enabled(parity_sel);
            par_bit_d  = parity_value(parity_sel, head_c);
            stop2_d    = stop_sel;
            baud_max_d = (baud_max_cnt == '0) ? BAUD_W'(1) : baud_max_cnt;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; txd idles high, including asynchronously on reset.
    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            baud_max_q <= BAUD_W'(1);
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            has_par_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            baud_max_q <= baud_max_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            has_par_q  <= has_par_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: a table of single-frame formats,
// plus sequences for back-to-back frames, overflow, reset abort, mid-frame
// config change and (with UART_TX_CTS_EN) clear-to-send gating. A serial
// monitor decodes txd against a scoreboard queue of expected frames.
module tb_uart_tx_buffered;

    logic        mclk = 1'b0;
    logic        n_reset;
    logic [15:0] baud_max_cnt;
    logic [1:0]  parity_sel;
    logic        stop_sel;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        cts_n;
    logic        full, empty, overflow, busy, done, txd;
    logic [4:0]  level;

    uart_tx_buffered dut (
        .mclk         (mclk),
        .n_reset      (n_reset),
        .baud_max_cnt (baud_max_cnt),
        .parity_sel   (parity_sel),
        .stop_sel     (stop_sel),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
`ifdef UART_TX_CTS_EN
        .cts_n        (cts_n),
`endif
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done),
        .txd          (txd)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  par;
        logic        stop2;
        logic [15:0] baud;
        logic        has_par;
        logic        par_bit;
    } frame_t;

    frame_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int chain_cnt = 0;
    bit mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge mclk) if (done === 1'b1) done_cnt++;

    // Decode one frame starting at the first sampled start-bit cycle.
    task automatic mon_frame(output bit carry);
        frame_t     f;
        logic [11:0] bits;
        int         nb;
        int         n;
        int         good;
        carry = 1'b0;
        if (sb_q.size() == 0) begin
            check("unexpected_frame", 32'(1), 32'(0));
            while (txd !== 1'b1) @(negedge mclk);
            return;
        end
        f = sb_q.pop_front();
        n = (f.baud == 16'd0) ? 1 : int'(f.baud);
        bits = '0;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin bits[nb] = f.data[i]; nb++; end
        if (f.has_par) begin bits[nb] = f.par_bit; nb++; end
        bits[nb] = 1'b1; nb++;
        if (f.stop2) begin bits[nb] = 1'b1; nb++; end
        for (int i = 0; i < nb; i++) begin
            good = 0;
            for (int c = 0; c < n; c++) begin
                if (i != 0 || c != 0) @(negedge mclk);
                if (n_reset !== 1'b1) return;
                if (txd === bits[i]) good++;
            end
            check($sformatf("frame_%02h_bit%0d_samples", f.data, i), 32'(good), 32'(n));
        end
        @(negedge mclk);
        if (n_reset !== 1'b1) return;
        check($sformatf("frame_%02h_done", f.data), 32'(done), 32'(1));
        carry = (txd === 1'b0);
        if (carry) chain_cnt++;
    endtask

    initial begin
        bit carry;
        carry = 1'b0;
        forever begin
            if (!carry) begin
                @(negedge mclk);
                while (!(n_reset === 1'b1 && txd === 1'b0)) @(negedge mclk);
            end
            mon_busy = 1'b1;
            mon_frame(carry);
            mon_busy = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge mclk);
        wr_en   = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic [1:0] par, input logic stop2,
                                input logic [15:0] baud, input logic has_par, input logic par_bit);
        frame_t f;
        f.data = d; f.par = par; f.stop2 = stop2; f.baud = baud;
        f.has_par = has_par; f.par_bit = par_bit;
        sb_q.push_back(f);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || mon_busy || busy !== 1'b0) && k < limit) begin
            @(negedge mclk);
            k++;
        end
        check({name, "_drain_in_time"}, 32'(k < limit), 32'(1));
        tick(2);
    endtask

    task automatic wait_done(input string name, input int limit);
        int k;
        k = 0;
        @(negedge mclk);
        while (done !== 1'b1 && k < limit) begin
            @(negedge mclk);
            k++;
        end
        check({name, "_done_in_time"}, 32'(k < limit), 32'(1));
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  par;
        logic        stop2;
        logic [15:0] baud;
        logic        has_par;
        logic        par_bit;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int d0, c0, k;
        bit stayed_high;

        tbl[0] = '{8'h55, 2'b01, 1'b0, 16'd4, 1'b1, 1'b0};
        tbl[1] = '{8'hA3, 2'b10, 1'b0, 16'd3, 1'b1, 1'b1};
        tbl[2] = '{8'h80, 2'b01, 1'b1, 16'd2, 1'b1, 1'b1};
        tbl[3] = '{8'h00, 2'b10, 1'b1, 16'd0, 1'b1, 1'b1};
        tbl[4] = '{8'h7E, 2'b00, 1'b0, 16'd1, 1'b0, 1'b0};
        tbl[5] = '{8'hC1, 2'b11, 1'b1, 16'd5, 1'b0, 1'b0};
        tbl[6] = '{8'h01, 2'b01, 1'b0, 16'd7, 1'b1, 1'b1};
        tbl[7] = '{8'hB4, 2'b10, 1'b0, 16'd2, 1'b1, 1'b1};

        n_reset = 1'b0; baud_max_cnt = 16'd4; parity_sel = 2'b00; stop_sel = 1'b0;
        wr_data = 8'h00; wr_en = 1'b0; cts_n = 1'b0;
        tick(3);
        check("rst_txd", 32'(txd), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_full", 32'(full), 32'(0));
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_level", 32'(level), 32'(0));
        n_reset = 1'b1;
        tick(3);
        check("post_rst_txd", 32'(txd), 32'(1));

        // Single frames across formats and bit periods, with push-to-start latency.
        for (int i = 0; i < 8; i++) begin
            parity_sel = tbl[i].par; stop_sel = tbl[i].stop2; baud_max_cnt = tbl[i].baud;
            d0 = done_cnt;
            expect_frame(tbl[i].data, tbl[i].par, tbl[i].stop2, tbl[i].baud, tbl[i].has_par, tbl[i].par_bit);
            push_byte(tbl[i].data);
            check($sformatf("tbl%0d_txd_before_pop", i), 32'(txd), 32'(1));
            @(negedge mclk);
            check($sformatf("tbl%0d_txd_start", i), 32'(txd), 32'(0));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(1));
            wait_drain($sformatf("tbl%0d", i), 2000);
            check($sformatf("tbl%0d_done_cnt", i), 32'(done_cnt - d0), 32'(1));
            check($sformatf("tbl%0d_busy_after", i), 32'(busy), 32'(0));
            check($sformatf("tbl%0d_empty", i), 32'(empty), 32'(1));
            check($sformatf("tbl%0d_txd_idle", i), 32'(txd), 32'(1));
        end

        // Back-to-back frames: no idle gap between stop and next start.
        parity_sel = 2'b10; stop_sel = 1'b0; baud_max_cnt = 16'd3;
        d0 = done_cnt; c0 = chain_cnt;
        expect_frame(8'hA3, 2'b10, 1'b0, 16'd3, 1'b1, 1'b1);
        expect_frame(8'h0F, 2'b10, 1'b0, 16'd3, 1'b1, 1'b1);
        expect_frame(8'hFF, 2'b10, 1'b0, 16'd3, 1'b1, 1'b1);
        push_byte(8'hA3); push_byte(8'h0F); push_byte(8'hFF);
        wait_drain("b2b", 2000);
        check("b2b_done_cnt", 32'(done_cnt - d0), 32'(3));
        check("b2b_chained", 32'(chain_cnt - c0), 32'(2));
        check("b2b_empty", 32'(empty), 32'(1));

        // Overflow: 17 accepted (1 in flight + 16 queued), 18th dropped.
        parity_sel = 2'b00; stop_sel = 1'b0; baud_max_cnt = 16'd3;
        for (int i = 0; i < 18; i++) begin
            if (i < 17) expect_frame(8'h10 + 8'(i), 2'b00, 1'b0, 16'd3, 1'b0, 1'b0);
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            @(negedge mclk);
            if (i == 16) begin
                check("ovf_full_at16", 32'(full), 32'(1));
                check("ovf_level_at16", 32'(level), 32'(16));
                check("ovf_no_pulse_yet", 32'(overflow), 32'(0));
            end
        end
        wr_en = 1'b0;
        check("ovf_pulse", 32'(overflow), 32'(1));
        check("ovf_level_kept", 32'(level), 32'(16));
        check("ovf_full_kept", 32'(full), 32'(1));
        @(negedge mclk);
        check("ovf_pulse_one_cycle", 32'(overflow), 32'(0));
        for (int i = 0; i < 3; i++) begin
            wait_done($sformatf("ovf_frame%0d", i), 500);
            check($sformatf("ovf_level_after_frame%0d", i), 32'(level), 32'(15 - i));
        end
        wait_drain("ovf", 5000);
        check("ovf_empty", 32'(empty), 32'(1));

        // Reset in the middle of the data bits aborts the frame.
        parity_sel = 2'b01; stop_sel = 1'b0; baud_max_cnt = 16'd4;
        expect_frame(8'h3C, 2'b01, 1'b0, 16'd4, 1'b1, 1'b0);
        push_byte(8'h3C);
        tick(14);
        check("rstmid_busy_before", 32'(busy), 32'(1));
        n_reset = 1'b0;
        #1;
        check("rstmid_txd_async", 32'(txd), 32'(1));
        check("rstmid_busy", 32'(busy), 32'(0));
        sb_q.delete();
        d0 = done_cnt;
        tick(3);
        n_reset = 1'b1;
        tick(1);
        check("rstmid_level", 32'(level), 32'(0));
        check("rstmid_empty", 32'(empty), 32'(1));
        stayed_high = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (txd !== 1'b1) stayed_high = 1'b0;
            @(negedge mclk);
        end
        check("rstmid_txd_stays_high", 32'(stayed_high), 32'(1));
        check("rstmid_no_done", 32'(done_cnt - d0), 32'(0));

        // Parity change mid-frame only affects the following frame.
        parity_sel = 2'b00; stop_sel = 1'b0; baud_max_cnt = 16'd2;
        expect_frame(8'h5A, 2'b00, 1'b0, 16'd2, 1'b0, 1'b0);
        expect_frame(8'h96, 2'b01, 1'b0, 16'd2, 1'b1, 1'b0);
        push_byte(8'h5A); push_byte(8'h96);
        tick(5);
        parity_sel = 2'b01;
        wait_drain("parchg", 2000);

`ifdef UART_TX_CTS_EN
        // Clear-to-send gating of frame starts.
        parity_sel = 2'b00; stop_sel = 1'b0; baud_max_cnt = 16'd3;
        cts_n = 1'b1;
        tick(3);
        expect_frame(8'h11, 2'b00, 1'b0, 16'd3, 1'b0, 1'b0);
        expect_frame(8'h22, 2'b00, 1'b0, 16'd3, 1'b0, 1'b0);
        push_byte(8'h11); push_byte(8'h22);
        tick(20);
        check("cts_held_txd", 32'(txd), 32'(1));
        check("cts_held_busy", 32'(busy), 32'(0));
        check("cts_held_level", 32'(level), 32'(2));
        cts_n = 1'b0;
        k = 0;
        while (txd !== 1'b0 && k < 10) begin
            @(negedge mclk);
            k++;
        end
        check("cts_start_latency_le4", 32'(k <= 4), 32'(1));
        tick(5);
        cts_n = 1'b1;
        wait_done("cts_first", 500);
        tick(10);
        check("cts_second_waits_level", 32'(level), 32'(1));
        check("cts_second_waits_busy", 32'(busy), 32'(0));
        check("cts_second_waits_txd", 32'(txd), 32'(1));
        cts_n = 1'b0;
        wait_drain("cts", 2000);
        check("cts_empty", 32'(empty), 32'(1));
`endif

        check("final_no_pending", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
